// File: rtl/alu_issue_stage.sv
// Registered RV32I decode/issue stage. Decodes opcode, func7_5 and
// alu_control, builds both ALU operands and holds the result in a
// two-entry (OUT + SKID) buffer behind a valid/ready handshake.
module alu_issue_stage #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [31:0]   instr_i,
    input  logic [DW-1:0] pc_i,
    input  logic [DW-1:0] rs1_data_i,
    input  logic [DW-1:0] rs2_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [6:0]    opcode_o,
    output logic          func7_5_o,
    output logic [2:0]    alu_control_o,
    output logic [DW-1:0] operand_1_o,
    output logic [DW-1:0] operand_2_o,
    output logic          illegal_o,
    output logic [31:0]   issue_cnt_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [6:0]    opcode;
        logic          f7_5;
        logic [2:0]    ctl;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic          illegal;
    } entry_t;

    logic [6:0]    opcode;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic [DW-1:0] imm_i;
    logic [DW-1:0] imm_s;
    logic [DW-1:0] imm_b;
    logic [DW-1:0] imm_j;
    logic [DW-1:0] imm_u;
    logic [DW-1:0] shamt;
    entry_t        dec_entry;

    entry_t        out_q, out_d;
    entry_t        skid_q, skid_d;
    logic          out_valid_q, out_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic [31:0]   cnt_q, cnt_d;

    logic          accept;
    logic          drain;
    logic          out_free;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];
    assign imm_i  = DW'($signed(instr_i[31:20]));
    assign imm_s  = DW'($signed({instr_i[31:25], instr_i[11:7]}));
    assign imm_b  = DW'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
    assign imm_j  = DW'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));
    assign imm_u  = DW'($signed({instr_i[31:12], 12'b0}));
    assign shamt  = DW'(instr_i[24:20]);

    // Decode the incoming instruction into an issue entry; illegal entries keep only the opcode.
    always_comb begin
        dec_entry        = '0;
        dec_entry.opcode = opcode;
        case (opcode)
            OP_R: begin
                dec_entry.ctl  = f3;
                dec_entry.f7_5 = instr_i[30];
                dec_entry.op1  = rs1_data_i;
                dec_entry.op2  = rs2_data_i;
                if (!((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)))))
                    dec_entry.illegal = 1'b1;
            end
            OP_I: begin
                dec_entry.ctl = f3;
                dec_entry.op1 = rs1_data_i;
                if (f3 == 3'b001) begin
                    dec_entry.f7_5 = instr_i[30];
                    dec_entry.op2  = shamt;
                    if (f7 != 7'h00) dec_entry.illegal = 1'b1;
                end else if (f3 == 3'b101) begin
                    dec_entry.f7_5 = instr_i[30];
                    dec_entry.op2  = shamt;
                    if ((f7 != 7'h00) && (f7 != 7'h20)) dec_entry.illegal = 1'b1;
                end else begin
                    dec_entry.op2 = imm_i;
                end
            end
            OP_LOAD:   begin dec_entry.op1 = rs1_data_i; dec_entry.op2 = imm_i; end
            OP_STORE:  begin dec_entry.op1 = rs1_data_i; dec_entry.op2 = imm_s; end
            OP_BRANCH: begin dec_entry.op1 = pc_i;       dec_entry.op2 = imm_b; end
            OP_JAL:    begin dec_entry.op1 = pc_i;       dec_entry.op2 = imm_j; end
            OP_JALR:   begin dec_entry.op1 = rs1_data_i; dec_entry.op2 = imm_i; end
            OP_LUI:    begin dec_entry.op1 = '0;         dec_entry.op2 = imm_u; end
            OP_AUIPC:  begin dec_entry.op1 = pc_i;       dec_entry.op2 = imm_u; end
            default:   dec_entry.illegal = 1'b1;
        endcase
        if (dec_entry.illegal) begin
            dec_entry.ctl  = '0;
            dec_entry.f7_5 = 1'b0;
            dec_entry.op1  = '0;
            dec_entry.op2  = '0;
        end
    end

    assign in_ready_o = ~skid_valid_q;
    assign accept     = in_valid_i & in_ready_o;
    assign drain      = out_valid_q & out_ready_i;
    assign out_free   = ~out_valid_q | out_ready_i;

    // Skid-buffer next state: SKID always refills OUT before any new entry, flush overrides all moves.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        cnt_d        = cnt_q + 32'(drain);
        if (flush_i) begin
            out_valid_d  = 1'b0;
            out_d        = '0;
            skid_valid_d = 1'b0;
            skid_d       = '0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_d        = skid_q;
                skid_valid_d = 1'b0;
                skid_d       = '0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_d       = dec_entry;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = dec_entry;
        end
    end

    // State registers; reset discards both entries and clears the transfer counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign opcode_o      = out_q.opcode;
    assign func7_5_o     = out_q.f7_5;
    assign alu_control_o = out_q.ctl;
    assign operand_1_o   = out_q.op1;
    assign operand_2_o   = out_q.op2;
    assign illegal_o     = out_q.illegal;
    assign issue_cnt_o   = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases plus random traffic
// compared each cycle against a queue-based reference of the issue buffer.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [6:0]  opcode_o;
    logic        func7_5_o;
    logic [2:0]  alu_control_o;
    logic [31:0] operand_1_o;
    logic [31:0] operand_2_o;
    logic        illegal_o;
    logic [31:0] issue_cnt_o;

    alu_issue_stage #(.DW(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .instr_i      (instr_i),
        .pc_i         (pc_i),
        .rs1_data_i   (rs1_data_i),
        .rs2_data_i   (rs2_data_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .opcode_o     (opcode_o),
        .func7_5_o    (func7_5_o),
        .alu_control_o(alu_control_o),
        .operand_1_o  (operand_1_o),
        .operand_2_o  (operand_2_o),
        .illegal_o    (illegal_o),
        .issue_cnt_o  (issue_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  opc;
        logic        f75;
        logic [2:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
    } ref_t;

    ref_t        q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_cnt  = 0;
    logic        last_acc = 0;

    // Reference decode written from the instruction-format rules with plain integer arithmetic.
    function automatic ref_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] r1, input logic [31:0] r2);
        ref_t        e;
        int          si;
        int unsigned op, f3, f7;
        logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
        si    = int'(ins);
        op    = ins & 32'h7F;
        f3    = (ins >> 12) & 7;
        f7    = ins >> 25;
        imm_i = 32'(si >>> 20);
        imm_s = 32'(((si >>> 25) <<< 5) | int'((ins >> 7) & 31));
        imm_b = 32'(((si >>> 31) <<< 12) | int'(((ins >> 7) & 1) << 11)
                    | int'(((ins >> 25) & 63) << 5) | int'(((ins >> 8) & 15) << 1));
        imm_j = 32'(((si >>> 31) <<< 20) | int'(((ins >> 12) & 255) << 12)
                    | int'(((ins >> 20) & 1) << 11) | int'(((ins >> 21) & 1023) << 1));
        imm_u = ins & 32'hFFFFF000;
        e.opc = 7'(op);
        e.f75 = 1'b0;
        e.ctl = 3'd0;
        e.a   = 32'd0;
        e.b   = 32'd0;
        e.ill = 1'b0;
        case (op)
            32'h33: begin
                e.ctl = 3'(f3); e.f75 = (f7 == 32'h20); e.a = r1; e.b = r2;
                e.ill = !(f7 == 0 || (f7 == 32'h20 && (f3 == 0 || f3 == 5)));
            end
            32'h13: begin
                e.ctl = 3'(f3); e.a = r1;
                if (f3 == 1 || f3 == 5) begin
                    e.f75 = (f7 == 32'h20);
                    e.b   = (ins >> 20) & 31;
                    e.ill = (f3 == 1) ? (f7 != 0) : !(f7 == 0 || f7 == 32'h20);
                end else begin
                    e.b = imm_i;
                end
            end
            32'h03: begin e.a = r1; e.b = imm_i; end
            32'h23: begin e.a = r1; e.b = imm_s; end
            32'h63: begin e.a = pc; e.b = imm_b; end
            32'h6F: begin e.a = pc; e.b = imm_j; end
            32'h67: begin e.a = r1; e.b = imm_i; end
            32'h37: begin e.a = 0;  e.b = imm_u; end
            32'h17: begin e.a = pc; e.b = imm_u; end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin
            e.ctl = 3'd0; e.f75 = 1'b0; e.a = 32'd0; e.b = 32'd0;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output with the reference buffer state.
    task automatic check_outputs();
        check("out_valid", 64'(out_valid_o), 64'(q.size() > 0));
        check("in_ready", 64'(in_ready_o), 64'(q.size() < 2));
        check("issue_cnt", 64'(issue_cnt_o), 64'(exp_cnt));
        if (q.size() > 0) begin
            check("opcode", 64'(opcode_o), 64'(q[0].opc));
            check("func7_5", 64'(func7_5_o), 64'(q[0].f75));
            check("alu_ctl", 64'(alu_control_o), 64'(q[0].ctl));
            check("operand_1", 64'(operand_1_o), 64'(q[0].a));
            check("operand_2", 64'(operand_2_o), 64'(q[0].b));
            check("illegal", 64'(illegal_o), 64'(q[0].ill));
        end
    endtask

    // One clock cycle: drive inputs, check outputs, then advance the reference at the edge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic ordy, input logic fl);
        logic acc, drn;
        in_valid_i  = v;
        instr_i     = ins;
        pc_i        = pc;
        rs1_data_i  = r1;
        rs2_data_i  = r2;
        out_ready_i = ordy;
        flush_i     = fl;
        check_outputs();
        acc = v && (q.size() < 2);
        drn = (q.size() > 0) && ordy;
        @(posedge clk);
        if (drn) exp_cnt++;
        if (fl) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(ref_decode(ins, pc, r1, r2));
        end
        last_acc = acc && !fl;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  ops [12];
        int          k, r;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F, 7'h33, 7'h13};
        ins = $urandom;
        k   = $urandom_range(0, 11);
        ins[6:0] = ops[k];
        if (k == 9) ins[6:0] = 7'($urandom);
        r = $urandom_range(0, 3);
        if (ins[6:0] == 7'h33 || ins[6:0] == 7'h13) begin
            if (r == 0 || r == 3) ins[31:25] = 7'h00;
            else if (r == 1)      ins[31:25] = 7'h20;
        end
        return ins;
    endfunction

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        instr_i = '0; pc_i = '0; rs1_data_i = '0; rs2_data_i = '0;
        #1;
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_in_ready", 64'(in_ready_o), 64'd1);
        check("rst_cnt", 64'(issue_cnt_o), 64'd0);
        check("rst_op1", 64'(operand_1_o), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back A,B,C with the consumer stalled: B lands in SKID, C waits.
        cycle(1, 32'h002081B3, 32'h0, 32'd1, 32'd2, 0, 0);
        cycle(1, 32'h402081B3, 32'h0, 32'd3, 32'd4, 0, 0);
        check("t4_in_ready_low", 64'(in_ready_o), 64'd0);
        cycle(1, 32'h00208133, 32'h0, 32'd5, 32'd6, 0, 0);
        cycle(1, 32'h00208133, 32'h0, 32'd5, 32'd6, 1, 0);
        for (int k = 0; k < 10 && !last_acc; k++)
            cycle(1, 32'h00208133, 32'h0, 32'd5, 32'd6, 1, 0);
        check("t4_c_accepted", 64'(last_acc), 64'd1);
        for (int k = 0; k < 10 && q.size() > 0; k++)
            cycle(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
        check("t4_empty", 64'(out_valid_o), 64'd0);
        check("t4_cnt", 64'(issue_cnt_o), 64'd3);

        cycle(1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1, 0);
        check("t1_valid", 64'(out_valid_o), 64'd1);
        check("t1_ctl", 64'(alu_control_o), 64'd0);
        check("t1_f75", 64'(func7_5_o), 64'd0);
        check("t1_op1", 64'(operand_1_o), 64'd5);
        check("t1_op2", 64'(operand_2_o), 64'd7);

        cycle(1, 32'h40415093, 32'h0, 32'h80000000, 32'h0, 1, 0);
        check("t2_srai_ctl", 64'(alu_control_o), 64'd5);
        check("t2_srai_f75", 64'(func7_5_o), 64'd1);
        check("t2_srai_op2", 64'(operand_2_o), 64'd4);
        cycle(1, 32'h402081B3, 32'h0, 32'd9, 32'd2, 1, 0);
        check("t2_sub_ctl", 64'(alu_control_o), 64'd0);
        check("t2_sub_f75", 64'(func7_5_o), 64'd1);

        cycle(1, 32'hFE000CE3, 32'h100, 32'd1, 32'd1, 1, 0);
        check("t3_beq_op1", 64'(operand_1_o), 64'h100);
        check("t3_beq_op2", 64'(operand_2_o), 64'hFFFFFFF8);
        check("t3_beq_ctl", 64'(alu_control_o), 64'd0);
        cycle(1, 32'h123450B7, 32'h200, 32'd3, 32'd3, 1, 0);
        check("t3_lui_op1", 64'(operand_1_o), 64'd0);
        check("t3_lui_op2", 64'(operand_2_o), 64'h12345000);

        cycle(1, 32'h0000007F, 32'h300, 32'd8, 32'd8, 1, 0);
        check("t5_opc_ill", 64'(illegal_o), 64'd1);
        check("t5_opc_op1", 64'(operand_1_o), 64'd0);
        cycle(1, 32'h022081B3, 32'h300, 32'd8, 32'd8, 1, 0);
        check("t5_f7_ill", 64'(illegal_o), 64'd1);
        check("t5_f7_op2", 64'(operand_2_o), 64'd0);
        check("t5_f7_ctl", 64'(alu_control_o), 64'd0);

        // Flush with both entries full; the same-cycle drain still counts.
        cycle(1, 32'h00500093, 32'h0, 32'd1, 32'd0, 0, 0);
        cycle(1, 32'h00600093, 32'h0, 32'd1, 32'd0, 0, 0);
        cycle(1, 32'h00700093, 32'h0, 32'd1, 32'd0, 1, 1);
        check("t6_flush_valid", 64'(out_valid_o), 64'd0);
        check("t6_flush_ready", 64'(in_ready_o), 64'd1);

        // Random traffic.
        for (int n = 0; n < 400; n++)
            cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0);

        // Asynchronous reset mid-stream with both entries occupied.
        cycle(1, 32'h00108093, 32'h0, 32'd1, 32'd0, 0, 0);
        cycle(1, 32'h00208093, 32'h0, 32'd1, 32'd0, 0, 0);
        in_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(out_valid_o), 64'd0);
        check("t6_rst_ready", 64'(in_ready_o), 64'd1);
        check("t6_rst_cnt", 64'(issue_cnt_o), 64'd0);
        check("t6_rst_opc", 64'(opcode_o), 64'd0);
        check("t6_rst_op1", 64'(operand_1_o), 64'd0);
        check("t6_rst_op2", 64'(operand_2_o), 64'd0);
        q.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 32'h00A00093, 32'h0, 32'd2, 32'd0, 1, 0);
        cycle(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
